// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one downstream memory port among PORTS requesters. Only one downstream
// transaction is outstanding at a time.
//
// Flow for each transaction:
//   1. A requester holds a command on its port.
//   2. The arbiter grants one requester and latches its command, address,
//      write data and mask.
//   3. The latched command is issued downstream once mem_busy_i is low.
//   4. On mem_done_i the granted requester gets read data (reads only) and a
//      one-cycle req_done_o pulse.
//
// Build option:
//   MEM_ARB_ROUND_ROBIN_EN  defined   : round-robin grant. The search starts
//                                       after the last granted port and wraps
//                                       from PORTS-1 to 0.
//                           undefined : fixed priority, lowest index wins.
//
// Parameters:
//   PORTS   number of requester ports (2..8)
//   ADDR_W  address width
//   DATA_W  data width (multiple of 8); mask width MW = DATA_W/8
//
// Ports:
//   clk, rst       clock (rising edge), synchronous active-high reset
//   req_rw_flag_i  per-port command, 2 bits each: 00 none, 01 read,
//                  10 write, 11 none
//   req_addr_i     per-port address
//   req_w_data_i   per-port write data
//   req_w_mask_i   per-port byte write mask
//   req_r_data_o   per-port read data, held until the next read completes
//   req_busy_o     per-port: request pending and not yet completed
//   req_done_o     per-port one-cycle completion pulse
//   mem_rw_flag_o  downstream command (same encoding), one cycle per issue
//   mem_addr_o     downstream address of the latched transaction
//   mem_w_data_o   downstream write data of the latched transaction
//   mem_w_mask_o   downstream write mask of the latched transaction
//   mem_r_data_i   downstream read data
//   mem_busy_i     downstream busy; stalls issue while high
//   mem_done_i     downstream completion
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int PORTS  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2*PORTS-1:0]          req_rw_flag_i,
    input  logic [ADDR_W*PORTS-1:0]     req_addr_i,
    input  logic [DATA_W*PORTS-1:0]     req_w_data_i,
    input  logic [(DATA_W/8)*PORTS-1:0] req_w_mask_i,
    output logic [DATA_W*PORTS-1:0]     req_r_data_o,
    output logic [PORTS-1:0]            req_busy_o,
    output logic [PORTS-1:0]            req_done_o,
    output logic [1:0]                  mem_rw_flag_o,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [DATA_W-1:0]           mem_w_data_o,
    output logic [(DATA_W/8)-1:0]       mem_w_mask_o,
    input  logic [DATA_W-1:0]           mem_r_data_i,
    input  logic                        mem_busy_i,
    input  logic                        mem_done_i
);

    localparam int MW    = DATA_W / 8;
    localparam int PTR_W = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [1:0] CMD_NONE  = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   grant_q;
    logic [1:0]         cmd_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [MW-1:0]      wmask_q;
    logic [PORTS-1:0]   done_q;
    logic [DATA_W-1:0]  rdata_q [PORTS];

    logic [PORTS-1:0]   valid;
    logic [PORTS-1:0]   done_hit;
    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic               grant_now;
    logic [1:0]         sel_cmd;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [MW-1:0]      sel_wmask;

    // Per-port decode, busy, completion and read-data registers.
    for (genvar g = 0; g < PORTS; g++) begin : g_port
        assign valid[g] = (req_rw_flag_i[2*g +: 2] == CMD_READ) ||
                          (req_rw_flag_i[2*g +: 2] == CMD_WRITE);

        assign done_hit[g] = (state_q == S_WAIT) && mem_done_i &&
                             (grant_q == PTR_W'(g));

        // A port is busy while it presents a command or owns the transaction.
        // In its completion cycle it is not busy, even if the command is held.
        assign req_busy_o[g] = !rst && !done_q[g] &&
                               (valid[g] ||
                                ((state_q != S_IDLE) && (grant_q == PTR_W'(g))));

        // NOTE: these are data registers, but they are visible outputs that
        // must read zero after reset, so they are reset like control state.
        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_q[g] <= '0;
            end else if (done_hit[g] && (cmd_q == CMD_READ)) begin
                rdata_q[g] <= mem_r_data_i;
            end
        end

        assign req_r_data_o[DATA_W*g +: DATA_W] = rdata_q[g];
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Last granted port. After reset it is PORTS-1, so port 0 is searched first.
    logic [PTR_W-1:0] last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= PTR_W'(PORTS - 1);
        end else if (grant_now) begin
            last_q <= win_idx;
        end
    end

    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= PORTS; k++) begin
            cand = (int'(last_q) + k) % PORTS;
            if (!win_found && valid[cand]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(cand);
            end
        end
    end
`else
    // Fixed priority. The loop scans downward, so the lowest requesting index
    // is written last and wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int p = PORTS - 1; p >= 0; p--) begin
            if (valid[p]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'(p);
            end
        end
    end
`endif

    // No grant is made in a completion cycle. This keeps a held command from
    // being reissued. In fixed-priority mode it also lets the lower-index port
    // keep the memory if it presents a new command right after its pulse.
    assign grant_now = (state_q == S_IDLE) && !(|done_q) && win_found;

    always_comb begin
        sel_cmd   = CMD_NONE;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wmask = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (win_idx == PTR_W'(p)) begin
                sel_cmd   = req_rw_flag_i[2*p +: 2];
                sel_addr  = req_addr_i[ADDR_W*p +: ADDR_W];
                sel_wdata = req_w_data_i[DATA_W*p +: DATA_W];
                sel_wmask = req_w_mask_i[MW*p +: MW];
            end
        end
    end

    // Next-state and downstream command.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        state_d       = state_q;
        mem_rw_flag_o = CMD_NONE;
        case (state_q)
            S_IDLE: begin
                if (grant_now) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!mem_busy_i) begin
                    mem_rw_flag_o = cmd_q;
                    state_d       = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments make all registers update together at
    // the edge, so the order of the statements below does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            cmd_q   <= CMD_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_hit;
            if (grant_now) begin
                grant_q <= win_idx;
                cmd_q   <= sel_cmd;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                wmask_q <= sel_wmask;
            end
        end
    end

    assign req_done_o   = done_q;
    assign mem_addr_o   = addr_q;
    assign mem_w_data_o = wdata_q;
    assign mem_w_mask_o = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter, built with PORTS = 4 and 32-bit
// address and data.
//
// Directed scenarios:
//   - reset values
//   - single read
//   - issue stall while mem_busy_i is high
//   - arbitration policy
//   - ports presenting the invalid command 11
//   - reset in the middle of a transaction
//
// Randomized run: random stimulus compared cycle by cycle against a behavioural
// model of the arbitration rules.
//
// The arbitration policy follows MEM_ARB_ROUND_ROBIN_EN, as in the design.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int PORTS  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MW     = DATA_W / 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [2*PORTS-1:0]      req_rw_flag_i;
    logic [ADDR_W*PORTS-1:0] req_addr_i;
    logic [DATA_W*PORTS-1:0] req_w_data_i;
    logic [MW*PORTS-1:0]     req_w_mask_i;
    logic [DATA_W*PORTS-1:0] req_r_data_o;
    logic [PORTS-1:0]        req_busy_o;
    logic [PORTS-1:0]        req_done_o;
    logic [1:0]              mem_rw_flag_o;
    logic [ADDR_W-1:0]       mem_addr_o;
    logic [DATA_W-1:0]       mem_w_data_o;
    logic [MW-1:0]           mem_w_mask_o;
    logic [DATA_W-1:0]       mem_r_data_i;
    logic                    mem_busy_i;
    logic                    mem_done_i;

    mem_port_arbiter #(
        .PORTS (PORTS),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_rw_flag_i(req_rw_flag_i),
        .req_addr_i   (req_addr_i),
        .req_w_data_i (req_w_data_i),
        .req_w_mask_i (req_w_mask_i),
        .req_r_data_o (req_r_data_o),
        .req_busy_o   (req_busy_o),
        .req_done_o   (req_done_o),
        .mem_rw_flag_o(mem_rw_flag_o),
        .mem_addr_o   (mem_addr_o),
        .mem_w_data_o (mem_w_data_o),
        .mem_w_mask_o (mem_w_mask_o),
        .mem_r_data_i (mem_r_data_i),
        .mem_busy_i   (mem_busy_i),
        .mem_done_i   (mem_done_i)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          resp_cnt = -1;
    logic [31:0] issued_q[$];

    // Inputs change 1 ns after the rising edge. Outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_rw_flag_i = '0;
        req_addr_i    = '0;
        req_w_data_i  = '0;
        req_w_mask_i  = '0;
        mem_r_data_i  = '0;
        mem_busy_i    = 1'b0;
        mem_done_i    = 1'b0;
    endtask

    task automatic set_port(input int p, input logic [1:0] f, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        req_rw_flag_i[2*p +: 2]       = f;
        req_addr_i[ADDR_W*p +: ADDR_W] = a;
        req_w_data_i[DATA_W*p +: DATA_W] = d;
        req_w_mask_i[MW*p +: MW]       = m;
    endtask

    // Returns in the first cycle with rst low. The caller drives that cycle.
    task automatic do_reset();
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        resp_cnt = -1;
    endtask

    // Simple downstream responder. It logs every issued address and raises
    // mem_done_i lat cycles after each issue.
    task automatic run_resp(input int cycles, input int lat, output int b1_low);
        b1_low = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            mem_done_i   = (resp_cnt == 0);
            mem_r_data_i = $urandom;
            if (resp_cnt == 0) resp_cnt = -1;
            else if (resp_cnt > 0) resp_cnt--;
            #1;
            if (mem_rw_flag_o != 2'b00) begin
                issued_q.push_back(mem_addr_o);
                resp_cnt = lat - 1;
            end
            if (req_busy_o[1] !== 1'b1) b1_low++;
        end
    endtask

    task automatic test_reset();
        tick();
        set_port(0, 2'b01, 32'h1234, 32'h0, 4'h0);
        set_port(2, 2'b10, 32'h5678, 32'h9, 4'hF);
        mem_done_i = 1'b1;
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b00) begin n_fail++; $display("FAIL reset_flag: got %b expected 00", mem_rw_flag_o); end
        n_checks++; if (mem_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
        n_checks++; if (mem_w_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", mem_w_data_o); end
        n_checks++; if (mem_w_mask_o !== 4'h0) begin n_fail++; $display("FAIL reset_wmask: got %h expected 0", mem_w_mask_o); end
        n_checks++; if (req_done_o !== 4'b0000) begin n_fail++; $display("FAIL reset_done: got %b expected 0000", req_done_o); end
        n_checks++; if (req_busy_o !== 4'b0000) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", req_busy_o); end
        n_checks++; if (req_r_data_o !== 128'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", req_r_data_o); end
    endtask

    task automatic test_single_read();
        do_reset();
        set_port(0, 2'b01, 32'h100, 32'h0, 4'h0);
        #1;
        n_checks++; if (req_busy_o !== 4'b0001) begin n_fail++; $display("FAIL read_busy_req: got %b expected 0001", req_busy_o); end
        n_checks++; if (mem_rw_flag_o !== 2'b00) begin n_fail++; $display("FAIL read_flag_req: got %b expected 00", mem_rw_flag_o); end
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b01) begin n_fail++; $display("FAIL read_issue_flag: got %b expected 01", mem_rw_flag_o); end
        n_checks++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL read_issue_addr: got %h expected 100", mem_addr_o); end
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b00) begin n_fail++; $display("FAIL read_one_cycle: got %b expected 00", mem_rw_flag_o); end
        n_checks++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL read_addr_hold: got %h expected 100", mem_addr_o); end
        tick();
        tick();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'hDEADBEEF;
        #1;
        n_checks++; if (req_done_o !== 4'b0000) begin n_fail++; $display("FAIL read_done_early: got %b expected 0000", req_done_o); end
        tick();
        mem_done_i   = 1'b0;
        mem_r_data_i = 32'h0;
        #1;
        n_checks++; if (req_done_o !== 4'b0001) begin n_fail++; $display("FAIL read_done_pulse: got %b expected 0001", req_done_o); end
        n_checks++; if (req_r_data_o[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data: got %h expected deadbeef", req_r_data_o[31:0]); end
        n_checks++; if (req_busy_o !== 4'b0000) begin n_fail++; $display("FAIL read_busy_done: got %b expected 0000", req_busy_o); end
        tick();
        set_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        n_checks++; if (req_done_o !== 4'b0000) begin n_fail++; $display("FAIL read_done_width: got %b expected 0000", req_done_o); end
        n_checks++; if (mem_rw_flag_o !== 2'b00) begin n_fail++; $display("FAIL read_no_reissue: got %b expected 00", mem_rw_flag_o); end
        n_checks++; if (req_r_data_o[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_data_hold: got %h expected deadbeef", req_r_data_o[31:0]); end
    endtask

    task automatic test_busy_stall();
        do_reset();
        set_port(0, 2'b10, 32'h40, 32'hA5A50000, 4'hC);
        mem_busy_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            mem_busy_i = 1'b1;
            #1;
            n_checks++; if (mem_rw_flag_o !== 2'b00) begin n_fail++; $display("FAIL stall_flag_%0d: got %b expected 00", i, mem_rw_flag_o); end
        end
        tick();
        mem_busy_i = 1'b0;
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b10) begin n_fail++; $display("FAIL stall_issue_flag: got %b expected 10", mem_rw_flag_o); end
        n_checks++; if ({mem_addr_o, mem_w_data_o, mem_w_mask_o} !== {32'h40, 32'hA5A50000, 4'hC})
            begin n_fail++; $display("FAIL stall_fields: got %h %h %h expected 40 a5a50000 c", mem_addr_o, mem_w_data_o, mem_w_mask_o); end
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b00) begin n_fail++; $display("FAIL stall_one_cycle: got %b expected 00", mem_rw_flag_o); end
        tick();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h77777777;
        tick();
        mem_done_i = 1'b0;
        set_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        n_checks++; if (req_done_o !== 4'b0001) begin n_fail++; $display("FAIL write_done: got %b expected 0001", req_done_o); end
        n_checks++; if (req_r_data_o[31:0] !== 32'h0) begin n_fail++; $display("FAIL write_no_rdata: got %h expected 0", req_r_data_o[31:0]); end
    endtask

    task automatic test_priority();
        int b1_low;
        do_reset();
        set_port(0, 2'b10, 32'h10, 32'h1, 4'hF);
        set_port(1, 2'b10, 32'h20, 32'h2, 4'hF);
        issued_q.delete();
        run_resp(22, 2, b1_low);
        n_checks++; if (issued_q.size() < 4) begin n_fail++; $display("FAIL prio_count: got %0d expected >=4", issued_q.size()); end
        else begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (issued_q[i] !== ((i % 2 == 0) ? 32'h10 : 32'h20)) begin
                    n_fail++; $display("FAIL rr_addr_%0d: got %h expected %h", i, issued_q[i], (i % 2 == 0) ? 32'h10 : 32'h20);
                end
            end
`else
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (issued_q[i] !== 32'h10) begin n_fail++; $display("FAIL fixed_addr_%0d: got %h expected 10", i, issued_q[i]); end
            end
            n_checks++; if (b1_low !== 0) begin n_fail++; $display("FAIL fixed_busy1: got %0d low cycles expected 0", b1_low); end
            set_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
            issued_q.delete();
            run_resp(12, 2, b1_low);
            n_checks++; if (issued_q.size() < 1) begin n_fail++; $display("FAIL fixed_p1_count: got %0d expected >=1", issued_q.size()); end
            else begin
                n_checks++; if (issued_q[0] !== 32'h20) begin n_fail++; $display("FAIL fixed_p1_addr: got %h expected 20", issued_q[0]); end
            end
`endif
        end
    endtask

    task automatic test_invalid_cmd();
        do_reset();
        set_port(1, 2'b11, 32'h111, 32'h0, 4'h0);
        set_port(3, 2'b11, 32'h333, 32'h0, 4'h0);
        set_port(2, 2'b01, 32'h200, 32'h0, 4'h0);
        #1;
        n_checks++; if (req_busy_o !== 4'b0100) begin n_fail++; $display("FAIL inv_busy: got %b expected 0100", req_busy_o); end
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b01 || mem_addr_o !== 32'h200) begin n_fail++; $display("FAIL inv_issue: got %b %h expected 01 200", mem_rw_flag_o, mem_addr_o); end
        n_checks++; if (req_busy_o !== 4'b0100) begin n_fail++; $display("FAIL inv_busy_issue: got %b expected 0100", req_busy_o); end
        tick();
        tick();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h22223333;
        tick();
        mem_done_i = 1'b0;
        #1;
        n_checks++; if (req_done_o !== 4'b0100) begin n_fail++; $display("FAIL inv_done: got %b expected 0100", req_done_o); end
        n_checks++; if (req_r_data_o !== {32'h0, 32'h22223333, 64'h0}) begin n_fail++; $display("FAIL inv_rdata: got %h expected 22223333 in port 2", req_r_data_o); end
        tick();
        set_port(2, 2'b00, 32'h0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            n_checks++; if (mem_rw_flag_o !== 2'b00 || req_busy_o !== 4'b0000) begin n_fail++; $display("FAIL inv_idle_%0d: got %b %b expected 00 0000", i, mem_rw_flag_o, req_busy_o); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_port(1, 2'b01, 32'h80, 32'h0, 4'h0);
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b01) begin n_fail++; $display("FAIL rmid_issue: got %b expected 01", mem_rw_flag_o); end
        tick();
        rst = 1'b1;
        set_port(1, 2'b00, 32'h0, 32'h0, 4'h0);
        tick();
        rst          = 1'b0;
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'hBAD0BAD0;
        #1;
        n_checks++; if ({mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o} !== 70'h0) begin n_fail++; $display("FAIL rmid_mem_zero: got %b %h %h %h expected 0", mem_rw_flag_o, mem_addr_o, mem_w_data_o, mem_w_mask_o); end
        n_checks++; if ({req_done_o, req_busy_o} !== 8'h0) begin n_fail++; $display("FAIL rmid_req_zero: got %b %b expected 0", req_done_o, req_busy_o); end
        tick();
        mem_done_i = 1'b0;
        #1;
        n_checks++; if (req_done_o !== 4'b0000) begin n_fail++; $display("FAIL rmid_no_done: got %b expected 0000", req_done_o); end
        n_checks++; if (req_r_data_o !== 128'h0) begin n_fail++; $display("FAIL rmid_rdata: got %h expected 0", req_r_data_o); end
        set_port(0, 2'b01, 32'h44, 32'h0, 4'h0);
        tick();
        #1;
        n_checks++; if (mem_rw_flag_o !== 2'b01 || mem_addr_o !== 32'h44) begin n_fail++; $display("FAIL rmid_next_issue: got %b %h expected 01 44", mem_rw_flag_o, mem_addr_o); end
        tick();
        mem_done_i   = 1'b1;
        mem_r_data_i = 32'h12345678;
        tick();
        mem_done_i = 1'b0;
        set_port(0, 2'b00, 32'h0, 32'h0, 4'h0);
        #1;
        n_checks++; if (req_done_o !== 4'b0001 || req_r_data_o[31:0] !== 32'h12345678) begin n_fail++; $display("FAIL rmid_next_done: got %b %h expected 0001 12345678", req_done_o, req_r_data_o[31:0]); end
    endtask

    // Arbitration rule: return the winning port among valid commands, or -1.
    function automatic int pick(input logic [PORTS-1:0] v, input int last);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= PORTS; k++) begin
            if (v[(last + k) % PORTS]) return (last + k) % PORTS;
        end
`else
        for (int p = 0; p < PORTS; p++) begin
            if (v[p]) return p;
        end
`endif
        return -1;
    endfunction

    task automatic test_random();
        bit                  active;
        bit                  issued;
        int                  tport;
        int                  pulse;
        int                  new_pulse;
        int                  last;
        int                  w;
        logic [1:0]          tcmd;
        logic [31:0]         taddr;
        logic [31:0]         tdata;
        logic [3:0]          tmask;
        logic [31:0]         rd_m [PORTS];
        logic [PORTS-1:0]    v;
        logic [PORTS-1:0]    exp_busy;
        logic [PORTS-1:0]    exp_done;
        logic [1:0]          exp_flag;
        logic [1:0]          f;
        logic [DATA_W*PORTS-1:0] exp_rd;

        do_reset();
        active = 1'b0; issued = 1'b0; tport = 0; pulse = -1; last = PORTS - 1;
        tcmd = 2'b00; taddr = '0; tdata = '0; tmask = '0;
        for (int p = 0; p < PORTS; p++) rd_m[p] = '0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc > 0) tick();
            for (int p = 0; p < PORTS; p++) begin
                if ($urandom_range(0, 99) < 25) begin
                    set_port(p, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)));
                end
            end
            mem_busy_i   = ($urandom_range(0, 99) < 30);
            mem_done_i   = ($urandom_range(0, 99) < 35);
            mem_r_data_i = $urandom;
            #1;

            for (int p = 0; p < PORTS; p++) begin
                f           = req_rw_flag_i[2*p +: 2];
                v[p]        = (f == 2'b01) || (f == 2'b10);
                exp_busy[p] = (p != pulse) && (v[p] || (active && tport == p));
                exp_done[p] = (p == pulse);
                exp_rd[DATA_W*p +: DATA_W] = rd_m[p];
            end
            exp_flag = (active && !issued && !mem_busy_i) ? tcmd : 2'b00;

            n_checks++; if (mem_rw_flag_o !== exp_flag) begin n_fail++; $display("FAIL rnd_flag cyc %0d: got %b expected %b", cyc, mem_rw_flag_o, exp_flag); end
            n_checks++; if (req_busy_o !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", cyc, req_busy_o, exp_busy); end
            n_checks++; if (req_done_o !== exp_done) begin n_fail++; $display("FAIL rnd_done cyc %0d: got %b expected %b", cyc, req_done_o, exp_done); end
            n_checks++; if (req_r_data_o !== exp_rd) begin n_fail++; $display("FAIL rnd_rdata cyc %0d: got %h expected %h", cyc, req_r_data_o, exp_rd); end
            if (active) begin
                n_checks++;
                if ({mem_addr_o, mem_w_data_o, mem_w_mask_o} !== {taddr, tdata, tmask}) begin
                    n_fail++; $display("FAIL rnd_fields cyc %0d: got %h %h %h expected %h %h %h", cyc, mem_addr_o, mem_w_data_o, mem_w_mask_o, taddr, tdata, tmask);
                end
            end

            new_pulse = -1;
            if (active) begin
                if (!issued) begin
                    if (!mem_busy_i) issued = 1'b1;
                end else if (mem_done_i) begin
                    if (tcmd == 2'b01) rd_m[tport] = mem_r_data_i;
                    new_pulse = tport;
                    active    = 1'b0;
                end
            end else if (pulse < 0) begin
                w = pick(v, last);
                if (w >= 0) begin
                    active = 1'b1;
                    issued = 1'b0;
                    tport  = w;
                    last   = w;
                    tcmd   = req_rw_flag_i[2*w +: 2];
                    taddr  = req_addr_i[ADDR_W*w +: ADDR_W];
                    tdata  = req_w_data_i[DATA_W*w +: DATA_W];
                    tmask  = req_w_mask_i[MW*w +: MW];
                end
            end
            pulse = new_pulse;
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_busy_stall();
        test_priority();
        test_invalid_cmd();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before the tests completed");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter PORTS, default 2: number of requester ports, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: address width.
REQ-003 SHALL have parameter DATA_W, default 32: data width, multiple of 8; mask width MW = DATA_W/8.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port req_rw_flag_i  in  2*PORTS  per-port command: 00 none, 01 read, 10 write, 11 treated as none.
REQ-007 SHALL have port req_addr_i  in  ADDR_W*PORTS  per-port address.
REQ-008 SHALL have port req_w_data_i  in  DATA_W*PORTS  per-port write data.
REQ-009 SHALL have port req_w_mask_i  in  MW*PORTS  per-port byte write mask.
REQ-010 SHALL have port req_r_data_o  out  DATA_W*PORTS  per-port read data.
REQ-011 SHALL have port req_busy_o  out  PORTS  per-port request pending, not yet completed.
REQ-012 SHALL have port req_done_o  out  PORTS  per-port one-cycle completion pulse.
REQ-013 SHALL have port mem_rw_flag_o  out  2  downstream command, same encoding.
REQ-014 SHALL have ports mem_addr_o (out, ADDR_W), mem_w_data_o (out, DATA_W), mem_w_mask_o (out, MW): downstream fields.
REQ-015 SHALL have ports mem_r_data_i (in, DATA_W), mem_busy_i (in, 1), mem_done_i (in, 1): downstream read data, busy, completion.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, WAIT; only one downstream transaction is outstanding at a time.
REQ-017 In IDLE, if any port has a valid command (01/10), SHALL grant one port, latch its command, address, data and mask into registers, and go to ISSUE the next cycle.
REQ-018 In ISSUE with mem_busy_i=0, SHALL drive mem_rw_flag_o with the latched command for exactly one cycle, then go to WAIT.
REQ-019 In ISSUE with mem_busy_i=1, SHALL hold mem_rw_flag_o=00 and stay in ISSUE.
REQ-020 mem_addr_o, mem_w_data_o, mem_w_mask_o SHALL hold the latched values from ISSUE through WAIT.
REQ-021 In WAIT, on mem_done_i=1, SHALL register mem_r_data_i into the granted port's req_r_data_o slice (reads only), pulse req_done_o[g] for one cycle in the next cycle, and return to IDLE.
REQ-022 req_r_data_o slices SHALL hold their value until the next read completion on the same port.
REQ-023 Minimum latency SHALL be: request seen in cycle T, downstream command in T+1, req_done_o one cycle after mem_done_i.
REQ-024 req_busy_o[p] SHALL be 1 whenever port p presents a valid command or is granted, and 0 in the cycle req_done_o[p] is 1 and while idle.
REQ-025 Requesters hold the command stable until req_done_o; the arbiter SHALL ignore port p's command in the cycle req_done_o[p]=1, so a held command is not reissued.
REQ-026 Command changes on a granted port after latching SHALL have no effect on the transaction in progress.
REQ-027 mem_done_i in IDLE or ISSUE SHALL be ignored.
REQ-028 Simultaneous requests SHALL be resolved by the configured priority (REQ-032/033); non-granted ports wait with req_busy_o=1.

Reset
REQ-029 With rst=1 at a clock edge, SHALL enter IDLE and set mem_rw_flag_o=00, mem_addr_o/mem_w_data_o/mem_w_mask_o=0, req_done_o=0, req_busy_o=0, req_r_data_o=0.
REQ-030 Reset mid-transaction SHALL abandon it; no req_done_o is generated for it.
REQ-031 Reset SHALL set the round-robin pointer to PORTS-1, so port 0 wins first.

Configuration
REQ-032 With macro MEM_ARB_ROUND_ROBIN_EN defined, SHALL grant the first requesting port after the last granted port, with wrap-around from PORTS-1 to 0.
REQ-033 Without MEM_ARB_ROUND_ROBIN_EN, SHALL use fixed priority, lowest index highest; the pointer is absent.

Verification
REQ-034 Single read: port 0 flag 01, addr 0x100; mem_done_i 3 cycles after issue with data 0xDEADBEEF -> mem_rw_flag_o=01 one cycle, req_done_o[0] pulse, req_r_data_o[0]=0xDEADBEEF.
REQ-035 Both ports write continuously (port0 addr 0x10, port1 addr 0x20), RR_EN defined -> downstream addresses 0x10,0x20,0x10,0x20.
REQ-036 Same stimulus, RR_EN undefined -> port 0 is served, port 1 waits with req_busy_o[1]=1 until port 0 drops its flag.
REQ-037 mem_busy_i=1 for 5 cycles during ISSUE -> mem_rw_flag_o stays 00 for 5 cycles, then 10 for one cycle.
REQ-038 rst asserted in WAIT, then mem_done_i=1 -> no req_done_o pulse, all outputs 0, next request served normally.
REQ-039 PORTS=4, ports 1 and 3 flag 11 and port 2 flag 01 -> only port 2 granted, req_busy_o=0100.
